// File: rtl/mdio_master.sv
`default_nettype none
// ============================================================================
// Module   : mdio_master
// Purpose  : IEEE 802.3 MDIO management master. Generates Clause-22 and
//            Clause-45 frames with configurable preamble on split tristate
//            pins, detects a missing PHY through the turnaround bit, and
//            offers a valid/ready request with a one-cycle response pulse.
// Ports    : clk, rst_n (async, active-low)
//            req_valid/req_ready        request handshake
//            req_c45/op/phy/reg/data    request fields
//            rsp_valid/rsp_data/rsp_err response (rsp_valid is a pulse)
//            busy                       transaction in progress
//            mdc, mdio_o, mdio_oe       management clock and MDIO drive
//            mdio_i                     MDIO pin input (asynchronous)
// Revision : 1.0 - initial release
// ============================================================================
module mdio_master #(
    parameter int CLK_DIV      = 6,
    parameter int PREAMBLE_LEN = 32,
    parameter int SUPPORT_C45  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_c45,
    input  logic [1:0]  req_op,
    input  logic [4:0]  req_phy,
    input  logic [4:0]  req_reg,
    input  logic [15:0] req_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    typedef enum logic [3:0] {
        IDLE = 4'd0, ERR = 4'd1, PRE = 4'd2, ST = 4'd3, OP = 4'd4,
        PHY  = 4'd5, REG = 4'd6, TA  = 4'd7, DATA = 4'd8, DONE = 4'd9
    } state_t;

    localparam logic [7:0] c_div_last = 8'(CLK_DIV - 1);
    localparam logic [4:0] c_pre_last = 5'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);
    localparam state_t     c_first    = (PREAMBLE_LEN > 0) ? PRE : ST;

    // Index of the last bit in each frame field.
    function automatic logic [4:0] field_last(input state_t s);
        case (s)
            PRE:         field_last = c_pre_last;
            ST, OP, TA:  field_last = 5'd1;
            PHY, REG:    field_last = 5'd4;
            DATA:        field_last = 5'd15;
            default:     field_last = 5'd0;
        endcase
    endfunction

    function automatic state_t field_next(input state_t s);
        case (s)
            PRE:     field_next = ST;
            ST:      field_next = OP;
            OP:      field_next = PHY;
            PHY:     field_next = REG;
            REG:     field_next = TA;
            TA:      field_next = DATA;
            default: field_next = DONE;
        endcase
    endfunction

    // Pin drive {oe, o} for bit cnt of field s. op[1] marks every read
    // opcode of both clauses (C22 10, C45 10/11). Released bits idle high.
    function automatic logic [1:0] bit_drive(input state_t s, input logic [4:0] cnt,
                                             input logic c45, input logic [1:0] op,
                                             input logic [4:0] phy, input logic [4:0] rg,
                                             input logic [15:0] d);
        logic [4:0]  phy_sh;
        logic [4:0]  rg_sh;
        logic [15:0] d_sh;
        phy_sh = phy << cnt;
        rg_sh  = rg << cnt;
        d_sh   = d << cnt;
        case (s)
            PRE:     bit_drive = 2'b11;
            ST:      bit_drive = {1'b1, c45 ? 1'b0 : cnt[0]};
            OP:      bit_drive = {1'b1, cnt[0] ? op[0] : op[1]};
            PHY:     bit_drive = {1'b1, phy_sh[4]};
            REG:     bit_drive = {1'b1, rg_sh[4]};
            TA:      bit_drive = op[1] ? 2'b01 : {1'b1, ~cnt[0]};
            DATA:    bit_drive = op[1] ? 2'b01 : {1'b1, d_sh[15]};
            default: bit_drive = 2'b01;
        endcase
    endfunction

    state_t      r_state, w_state_n, w_adv_state;
    logic [4:0]  r_cnt, w_cnt_n, w_adv_cnt;
    logic [7:0]  r_div, w_div_n;
    logic        r_mdc, w_mdc_n;
    logic        r_mdio_o, w_mdio_o_n;
    logic        r_mdio_oe, w_mdio_oe_n;
    logic        r_busy, w_busy_n;
    logic        r_rsp_valid, w_rsp_valid_n;
    logic        r_rsp_err, w_rsp_err_n;
    logic [15:0] r_rsp_data, w_rsp_data_n;
    logic        r_c45, w_c45_n;
    logic [1:0]  r_op, w_op_n;
    logic [4:0]  r_phy, w_phy_n;
    logic [4:0]  r_reg, w_reg_n;
    logic [15:0] r_wdata, w_wdata_n;
    logic [15:0] r_rdata, w_rdata_n;
    logic        r_ta_err, w_ta_err_n;
    logic        r_sync1, r_sync2;
    logic        w_legal;

    assign w_legal = req_c45 ? (SUPPORT_C45 != 0) : (req_op == 2'b01 || req_op == 2'b10);

    always_comb begin
        w_state_n     = r_state;
        w_cnt_n       = r_cnt;
        w_div_n       = r_div;
        w_mdc_n       = r_mdc;
        w_mdio_o_n    = r_mdio_o;
        w_mdio_oe_n   = r_mdio_oe;
        w_busy_n      = r_busy;
        w_rsp_valid_n = 1'b0;
        w_rsp_err_n   = r_rsp_err;
        w_rsp_data_n  = r_rsp_data;
        w_c45_n       = r_c45;
        w_op_n        = r_op;
        w_phy_n       = r_phy;
        w_reg_n       = r_reg;
        w_wdata_n     = r_wdata;
        w_rdata_n     = r_rdata;
        w_ta_err_n    = r_ta_err;
        w_adv_state   = r_state;
        w_adv_cnt     = r_cnt;
        case (r_state)
            IDLE: begin
                if (req_valid && !r_busy) begin
                    w_c45_n    = req_c45;
                    w_op_n     = req_op;
                    w_phy_n    = req_phy;
                    w_reg_n    = req_reg;
                    w_wdata_n  = req_data;
                    w_busy_n   = 1'b1;
                    w_ta_err_n = 1'b0;
                    w_cnt_n    = 5'd0;
                    w_div_n    = 8'd0;
                    w_mdc_n    = 1'b0;
                    if (!w_legal) begin
                        w_state_n = ERR;
                    end else begin
                        // First bit goes onto the pins straight from the request.
                        w_state_n = c_first;
                        {w_mdio_oe_n, w_mdio_o_n} = bit_drive(c_first, 5'd0, req_c45, req_op,
                                                              req_phy, req_reg, req_data);
                    end
                end
            end
            ERR: begin
                w_state_n     = IDLE;
                w_busy_n      = 1'b0;
                w_rsp_valid_n = 1'b1;
                w_rsp_err_n   = 1'b1;
            end
            DONE: begin
                w_state_n     = IDLE;
                w_busy_n      = 1'b0;
                w_rsp_valid_n = 1'b1;
                w_rsp_err_n   = r_ta_err;
                if (r_op[1]) begin
                    w_rsp_data_n = r_rdata;
                end
            end
            default: begin
                if (r_div != c_div_last) begin
                    w_div_n = r_div + 8'd1;
                end else begin
                    w_div_n = 8'd0;
                    if (!r_mdc) begin
                        // Rising MDC: sample the synchronised input for reads.
                        w_mdc_n = 1'b1;
                        if (r_op[1] && r_state == TA && r_cnt == 5'd1) begin
                            w_ta_err_n = r_sync2;
                        end
                        if (r_op[1] && r_state == DATA) begin
                            w_rdata_n = {r_rdata[14:0], r_sync2};
                        end
                    end else begin
                        // Falling MDC: advance to the next bit and drive it.
                        w_mdc_n = 1'b0;
                        if (r_cnt == field_last(r_state)) begin
                            w_adv_state = field_next(r_state);
                            w_adv_cnt   = 5'd0;
                        end else begin
                            w_adv_cnt   = r_cnt + 5'd1;
                        end
                        w_state_n = w_adv_state;
                        w_cnt_n   = w_adv_cnt;
                        {w_mdio_oe_n, w_mdio_o_n} = bit_drive(w_adv_state, w_adv_cnt, r_c45, r_op,
                                                              r_phy, r_reg, r_wdata);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 5'd0;
            r_div       <= 8'd0;
            r_mdc       <= 1'b0;
            r_mdio_o    <= 1'b1;
            r_mdio_oe   <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_data  <= 16'd0;
            r_c45       <= 1'b0;
            r_op        <= 2'b00;
            r_phy       <= 5'd0;
            r_reg       <= 5'd0;
            r_wdata     <= 16'd0;
            r_rdata     <= 16'd0;
            r_ta_err    <= 1'b0;
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
        end else begin
            r_state     <= w_state_n;
            r_cnt       <= w_cnt_n;
            r_div       <= w_div_n;
            r_mdc       <= w_mdc_n;
            r_mdio_o    <= w_mdio_o_n;
            r_mdio_oe   <= w_mdio_oe_n;
            r_busy      <= w_busy_n;
            r_rsp_valid <= w_rsp_valid_n;
            r_rsp_err   <= w_rsp_err_n;
            r_rsp_data  <= w_rsp_data_n;
            r_c45       <= w_c45_n;
            r_op        <= w_op_n;
            r_phy       <= w_phy_n;
            r_reg       <= w_reg_n;
            r_wdata     <= w_wdata_n;
            r_rdata     <= w_rdata_n;
            r_ta_err    <= w_ta_err_n;
            r_sync1     <= mdio_i;
            r_sync2     <= r_sync1;
        end
    end

    assign req_ready = !r_busy;
    assign busy      = r_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_data  = r_rsp_data;
    assign mdc       = r_mdc;
    assign mdio_o    = r_mdio_o;
    assign mdio_oe   = r_mdio_oe;

endmodule
`default_nettype wire

// File: tb/tb_mdio_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdio_master
// Purpose  : Self-checking bench for mdio_master. Three instances (default,
//            Clause-45 disabled, fast/no-preamble) share the request inputs;
//            sel routes req_valid to one of them and muxes its outputs back.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdio_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, req_valid, req_c45, mdio_i;
    logic [1:0]  req_op, sel;
    logic [4:0]  req_phy, req_reg;
    logic [15:0] req_data;

    logic [2:0]  valid_v, ready_v, rvalid_v, err_v, busy_v, mdc_v, o_v, oe_v;
    logic [15:0] rd0, rd1, rd2;

    assign valid_v[0] = req_valid && (sel == 2'd0);
    assign valid_v[1] = req_valid && (sel == 2'd1);
    assign valid_v[2] = req_valid && (sel == 2'd2);

    logic        m_ready, m_rvalid, m_err, m_busy, m_mdc, m_o, m_oe;
    logic [15:0] m_rdata;
    assign m_ready  = ready_v[sel];
    assign m_rvalid = rvalid_v[sel];
    assign m_err    = err_v[sel];
    assign m_busy   = busy_v[sel];
    assign m_mdc    = mdc_v[sel];
    assign m_o      = o_v[sel];
    assign m_oe     = oe_v[sel];
    assign m_rdata  = (sel == 2'd0) ? rd0 : (sel == 2'd1) ? rd1 : rd2;

    mdio_master u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(valid_v[0]), .req_ready(ready_v[0]),
        .req_c45(req_c45), .req_op(req_op), .req_phy(req_phy), .req_reg(req_reg),
        .req_data(req_data), .rsp_valid(rvalid_v[0]), .rsp_data(rd0), .rsp_err(err_v[0]),
        .busy(busy_v[0]), .mdc(mdc_v[0]), .mdio_o(o_v[0]), .mdio_oe(oe_v[0]), .mdio_i(mdio_i)
    );

    mdio_master #(.SUPPORT_C45(0)) u_nc45 (
        .clk(clk), .rst_n(rst_n), .req_valid(valid_v[1]), .req_ready(ready_v[1]),
        .req_c45(req_c45), .req_op(req_op), .req_phy(req_phy), .req_reg(req_reg),
        .req_data(req_data), .rsp_valid(rvalid_v[1]), .rsp_data(rd1), .rsp_err(err_v[1]),
        .busy(busy_v[1]), .mdc(mdc_v[1]), .mdio_o(o_v[1]), .mdio_oe(oe_v[1]), .mdio_i(mdio_i)
    );

    mdio_master #(.CLK_DIV(2), .PREAMBLE_LEN(0)) u_fast (
        .clk(clk), .rst_n(rst_n), .req_valid(valid_v[2]), .req_ready(ready_v[2]),
        .req_c45(req_c45), .req_op(req_op), .req_phy(req_phy), .req_reg(req_reg),
        .req_data(req_data), .rsp_valid(rvalid_v[2]), .rsp_data(rd2), .rsp_err(err_v[2]),
        .busy(busy_v[2]), .mdc(mdc_v[2]), .mdio_o(o_v[2]), .mdio_oe(oe_v[2]), .mdio_i(mdio_i)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference parameters of each instance
    function automatic int p_of(input logic [1:0] s);
        return (s == 2'd2) ? 0 : 32;
    endfunction
    function automatic int d_of(input logic [1:0] s);
        return (s == 2'd2) ? 2 : 6;
    endfunction
    function automatic bit legal_req(input logic [1:0] s, input logic c45, input logic [1:0] op);
        if (c45) return (s != 2'd1);
        return (op == 2'b01) || (op == 2'b10);
    endfunction

    logic [15:0] last_data [3];

    // Observations from the most recent transaction
    int          r_lat, r_rises, chg_viol, per_viol, end_viol, first_rise;
    logic [63:0] obs_bits, obs_oe;
    logic        r_err, first_o, first_oe;

    // Presents a request in the current cycle and follows the pins until the
    // response pulse. The PHY model drives each bit right after the MDC rise
    // of the previous bit, like a real PHY's clock-to-out.
    task automatic run_txn(input logic [1:0] s, input logic c45, input logic [1:0] op,
                           input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] data,
                           input logic phy_ok, input logic [15:0] word, input bit hold,
                           input int abort_rises);
        int cyc, p, d, last_rise;
        logic pm, po, poe;
        logic [15:0] wsh;
        p = p_of(s);
        d = d_of(s);
        sel = s; req_valid = 1'b1; req_c45 = c45; req_op = op;
        req_phy = phy; req_reg = rg; req_data = data;
        #1;
        chk("accept_ready", m_ready, 1'b1);
        cyc = 0; r_rises = 0; obs_bits = '0; obs_oe = '0; r_lat = -1; r_err = 1'bx;
        chg_viol = 0; per_viol = 0; end_viol = 0; last_rise = -1; first_rise = -1;
        pm = m_mdc; po = m_o; poe = m_oe;
        while (cyc < 1200) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                req_valid = hold;
                first_o  = m_o;
                first_oe = m_oe;
                chk("busy_after_accept", m_busy, 1'b1);
                chk("rsp_pulse_len", m_rvalid, 1'b0);
            end
            if (cyc > 1 && ({m_oe, m_o} != {poe, po}) && !(pm && !m_mdc)) chg_viol++;
            if (m_mdc && !pm) begin
                if (last_rise < 0) first_rise = cyc;
                else if (cyc - last_rise != 2 * d) per_viol++;
                last_rise = cyc;
                obs_bits = {obs_bits[62:0], m_o};
                obs_oe   = {obs_oe[62:0], m_oe};
                r_rises++;
                // drive bit number r_rises
                mdio_i = 1'b1;
                if (phy_ok && op[1]) begin
                    if (r_rises == p + 15) mdio_i = 1'b0;
                    else if (r_rises >= p + 16 && r_rises <= p + 31) begin
                        wsh = word << (r_rises - p - 16);
                        mdio_i = wsh[15];
                    end
                end
                if (r_rises == abort_rises) return;
            end
            if (m_rvalid) begin
                r_lat  = cyc;
                r_err  = m_err;
                if (m_busy || !m_ready || m_mdc || m_oe) end_viol++;
                break;
            end
            pm = m_mdc; po = m_o; poe = m_oe;
        end
        mdio_i = 1'b1;
    endtask

    task automatic check_legal(input logic [1:0] s, input logic c45, input logic [1:0] op,
                               input logic [4:0] phy, input logic [4:0] rg, input logic [15:0] data,
                               input logic phy_ok, input logic [15:0] word);
        int p, d, n;
        logic [63:0] ef, eo, mask;
        logic [13:0] hdr;
        logic [17:0] tail;
        bit rd;
        p = p_of(s); d = d_of(s); n = p + 32;
        rd = op[1];
        hdr = {(c45 ? 2'b00 : 2'b01), op, phy, rg};
        tail = {2'b10, data};
        ef = '0; eo = '0; mask = '0;
        for (int i = 0; i < p; i++) begin
            ef = {ef[62:0], 1'b1}; eo = {eo[62:0], 1'b1}; mask = {mask[62:0], 1'b1};
        end
        for (int i = 13; i >= 0; i--) begin
            ef = {ef[62:0], hdr[i]}; eo = {eo[62:0], 1'b1}; mask = {mask[62:0], 1'b1};
        end
        for (int i = 17; i >= 0; i--) begin
            ef   = {ef[62:0], rd ? 1'b0 : tail[i]};
            eo   = {eo[62:0], !rd};
            mask = {mask[62:0], !rd};
        end
        if (rd) last_data[s] = phy_ok ? word : 16'hFFFF;
        chk("mdc_rises", r_rises, n);
        chk("frame_bits", obs_bits & mask, ef);
        chk("frame_oe", obs_oe, eo);
        chk("latency", r_lat, n * 2 * d + 2);
        chk("rsp_err", r_err, rd && !phy_ok);
        chk("rsp_data", m_rdata, last_data[s]);
        chk("first_bit", {first_oe, first_o}, {1'b1, (p > 0)});
        chk("first_rise", first_rise, d + 1);
        chk("pin_change_on_fall", chg_viol, 0);
        chk("mdc_period", per_viol, 0);
        chk("end_state", end_viol, 0);
    endtask

    task automatic check_illegal(input logic [1:0] s);
        chk("ill_latency", r_lat, 2);
        chk("ill_err", r_err, 1'b1);
        chk("ill_no_mdc", r_rises, 0);
        chk("ill_no_drive", first_oe, 1'b0);
        chk("ill_data_kept", m_rdata, last_data[s]);
        chk("ill_end_state", end_viol, 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  s, op;
        logic        c45, ok;
        logic [4:0]  phy, rg;
        logic [15:0] data, word;
        int          cnt_rv, cnt_mdc;

        rst_n = 1'b0; req_valid = 1'b0; req_c45 = 1'b0; req_op = 2'b00;
        req_phy = '0; req_reg = '0; req_data = '0; mdio_i = 1'b1; sel = 2'd0;
        for (int i = 0; i < 3; i++) last_data[i] = 16'h0000;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            sel = 2'(i);
            #1;
            chk("rst_ready", m_ready, 1'b1);
            chk("rst_busy", m_busy, 1'b0);
            chk("rst_rsp", {m_rvalid, m_err, m_rdata}, 18'h0);
            chk("rst_pins", {m_mdc, m_o, m_oe}, 3'b010);
        end
        @(negedge clk);

        // C22 write, default parameters
        run_txn(2'd0, 1'b0, 2'b01, 5'h01, 5'h00, 16'h1140, 1'b1, 16'h0, 1'b0, 0);
        check_legal(2'd0, 1'b0, 2'b01, 5'h01, 5'h00, 16'h1140, 1'b1, 16'h0);
        @(negedge clk);

        // C22 read with a responding PHY
        run_txn(2'd0, 1'b0, 2'b10, 5'h03, 5'h02, 16'h0, 1'b1, 16'h796D, 1'b0, 0);
        check_legal(2'd0, 1'b0, 2'b10, 5'h03, 5'h02, 16'h0, 1'b1, 16'h796D);

        // C22 read, nobody answers
        run_txn(2'd0, 1'b0, 2'b10, 5'h07, 5'h01, 16'h0, 1'b0, 16'h0, 1'b0, 0);
        check_legal(2'd0, 1'b0, 2'b10, 5'h07, 5'h01, 16'h0, 1'b0, 16'h0);

        // C45 address then read, request held valid across the response
        run_txn(2'd0, 1'b1, 2'b00, 5'h02, 5'h01, 16'h0007, 1'b1, 16'h0, 1'b1, 0);
        check_legal(2'd0, 1'b1, 2'b00, 5'h02, 5'h01, 16'h0007, 1'b1, 16'h0);
        run_txn(2'd0, 1'b1, 2'b11, 5'h02, 5'h01, 16'h0, 1'b1, 16'hA5C3, 1'b0, 0);
        check_legal(2'd0, 1'b1, 2'b11, 5'h02, 5'h01, 16'h0, 1'b1, 16'hA5C3);

        // C45 rejected when unsupported; illegal C22 opcode
        run_txn(2'd1, 1'b1, 2'b00, 5'h02, 5'h01, 16'h0007, 1'b1, 16'h0, 1'b0, 0);
        check_illegal(2'd1);
        run_txn(2'd0, 1'b0, 2'b11, 5'h02, 5'h01, 16'h1234, 1'b1, 16'h0, 1'b0, 0);
        check_illegal(2'd0);

        // No preamble, CLK_DIV=2
        run_txn(2'd2, 1'b0, 2'b01, 5'h1F, 5'h15, 16'hBEEF, 1'b1, 16'h0, 1'b0, 0);
        check_legal(2'd2, 1'b0, 2'b01, 5'h1F, 5'h15, 16'hBEEF, 1'b1, 16'h0);

        // Randomised traffic
        for (int k = 0; k < 8; k++) begin
            s    = ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd2;
            c45  = 1'($urandom_range(0, 1));
            op   = 2'($urandom_range(0, 3));
            phy  = 5'($urandom);
            rg   = 5'($urandom);
            data = 16'($urandom);
            word = 16'($urandom);
            ok   = ($urandom_range(0, 3) != 0);
            run_txn(s, c45, op, phy, rg, data, ok, word, 1'b0, 0);
            if (legal_req(s, c45, op)) check_legal(s, c45, op, phy, rg, data, ok, word);
            else check_illegal(s);
            @(negedge clk);
        end

        // Reset in the middle of PHYAD of a read
        run_txn(2'd0, 1'b0, 2'b10, 5'h0A, 5'h03, 16'h0, 1'b1, 16'h1357, 1'b0, 32 + 6);
        chk("pre_rst_busy", m_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_mdc", m_mdc, 1'b0);
        chk("mid_rst_oe", m_oe, 1'b0);
        chk("mid_rst_busy", m_busy, 1'b0);
        chk("mid_rst_rsp", m_rvalid, 1'b0);
        last_data[0] = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt_rv = 0; cnt_mdc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (m_rvalid) cnt_rv++;
            if (m_mdc) cnt_mdc++;
        end
        chk("post_rst_no_rsp", cnt_rv, 0);
        chk("post_rst_no_mdc", cnt_mdc, 0);
        run_txn(2'd0, 1'b0, 2'b10, 5'h0A, 5'h03, 16'h0, 1'b1, 16'h2468, 1'b0, 0);
        check_legal(2'd0, 1'b0, 2'b10, 5'h0A, 5'h03, 16'h0, 1'b1, 16'h2468);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
